// File: rtl/cgra_ctrl_pkg.sv
// Shared types for the per-tile configuration sequencer: config word type,
// sequencer state encoding and the config word width.
package cgra_ctrl_pkg;

  localparam int unsigned CTRL_W = 49;

  typedef logic [CTRL_W-1:0] CGRAConfig_6_4_6_8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrl_seq_state_e;

endpackage

// File: rtl/ctrl_rf_1r1w.sv
// Configuration storage: one combinational read port, one posedge write port.
// Contents are deliberately not reset.
module ctrl_rf_1r1w
  import cgra_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CTRL = 4,
  localparam int unsigned ADDR_W = $clog2(NUM_CTRL)
) (
  input  logic              clk_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  CGRAConfig_6_4_6_8 wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output CGRAConfig_6_4_6_8 rdata_o
);

  CGRAConfig_6_4_6_8 mem_q [NUM_CTRL];

  always_ff @(posedge clk_i) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ctrl_mem_sequencer.sv
// Loads config words while idle, then streams entries 0..steps-1 cyclically to
// the tile and counts passes. Optional iteration limit: CTRL_SEQ_ITER_LIMIT_EN.
module ctrl_mem_sequencer
  import cgra_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CTRL = 4,
  parameter int unsigned ITER_W   = 16,
  localparam int unsigned ADDR_W  = $clog2(NUM_CTRL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  CGRAConfig_6_4_6_8 load_data,
  input  logic [ADDR_W:0]   num_steps,
  input  logic              start,
  input  logic              stop,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output CGRAConfig_6_4_6_8 ctrl_data,
  output logic              busy,
  output logic [ITER_W-1:0] iter_count
`ifdef CTRL_SEQ_ITER_LIMIT_EN
  ,
  input  logic [ITER_W-1:0] iter_limit,
  output logic              done
`endif
);

  localparam logic [ADDR_W:0] StepsMax = (ADDR_W + 1)'(NUM_CTRL);

  ctrl_seq_state_e   state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   steps_q, steps_d, steps_in;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  logic              fire, wrap, restart;

  assign fire     = ctrl_valid && ctrl_ready;
  assign wrap     = ({1'b0, rd_ptr_q} == (steps_q - (ADDR_W + 1)'(1)));
  assign iter_inc = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
  assign steps_in = ((num_steps == '0) || (num_steps > StepsMax)) ? StepsMax : num_steps;
  // Any entry into RUN from a non-RUN state re-samples the run parameters.
  assign restart  = (state_d == RUN) && (state_q != RUN);

`ifdef CTRL_SEQ_ITER_LIMIT_EN
  logic [ITER_W-1:0] limit_q, limit_d;
  logic              limit_hit;

  assign limit_hit = fire && wrap && (limit_q != '0) && (iter_inc == limit_q);
  assign limit_d   = restart ? iter_limit : limit_q;

  always_ff @(posedge clk) begin
    if (reset) limit_q <= '0;
    else       limit_q <= limit_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop) state_d = IDLE;
`ifdef CTRL_SEQ_ITER_LIMIT_EN
        else if (limit_hit) state_d = DONE;
`endif
      end
`ifdef CTRL_SEQ_ITER_LIMIT_EN
      DONE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_valid = (state_q == RUN);
    busy       = (state_q != IDLE);
    load_ready = (state_q == IDLE);
`ifdef CTRL_SEQ_ITER_LIMIT_EN
    done       = (state_q == DONE);
`endif
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    steps_d  = steps_q;
    iter_d   = iter_q;
    if (restart) begin
      rd_ptr_d = '0;
      steps_d  = steps_in;
      iter_d   = '0;
    end else if (fire) begin
      rd_ptr_d = wrap ? '0 : rd_ptr_q + ADDR_W'(1);
      if (wrap) iter_d = iter_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      steps_q  <= StepsMax;
      iter_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      steps_q  <= steps_d;
      iter_q   <= iter_d;
    end
  end

  assign iter_count = iter_q;

  ctrl_rf_1r1w #(
    .NUM_CTRL (NUM_CTRL)
  ) u_rf (
    .clk_i   (clk),
    .wen_i   (load_valid && load_ready),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ctrl_data)
  );

endmodule

// File: tb/tb_ctrl_mem_sequencer.sv
// Scoreboard bench for ctrl_mem_sequencer: directed scenarios followed by random traffic,
// checked against a behavioural model of the sequencer.
module tb_ctrl_mem_sequencer;
  import cgra_ctrl_pkg::*;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_ready;
  logic [1:0]  load_addr;
  logic [48:0] load_data;
  logic [2:0]  num_steps;
  logic        start, stop;
  logic        ctrl_valid, ctrl_ready;
  logic [48:0] ctrl_data;
  logic        busy;
  logic [15:0] iter_count;
`ifdef CTRL_SEQ_ITER_LIMIT_EN
  logic [15:0] iter_limit = '0;
  logic        done;
`endif

  always #5 clk = ~clk;

  ctrl_mem_sequencer #(
    .NUM_CTRL (NC),
    .ITER_W   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .num_steps  (num_steps),
    .start      (start),
    .stop       (stop),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl_data  (ctrl_data),
    .busy       (busy),
    .iter_count (iter_count)
`ifdef CTRL_SEQ_ITER_LIMIT_EN
    ,
    .iter_limit (iter_limit),
    .done       (done)
`endif
  );

  typedef struct {
    logic [48:0] data;
    int          iter;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;

  // Behavioural model: stored words, running flag, position and passes completed.
  logic [48:0] m_mem[NC];
  bit          m_run;
  int          m_ptr, m_steps, m_iter;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [48:0] rand_word();
    return {17'($urandom()), $urandom()};
  endfunction

  task automatic step(bit lv, int la, logic [48:0] ld, bit st, int ns, bit sp, bit rdy);
    load_valid = lv;
    load_addr  = 2'(la);
    load_data  = ld;
    start      = st;
    num_steps  = 3'(ns);
    stop       = sp;
    ctrl_ready = rdy;
    if (m_run && rdy) exp_q.push_back('{m_mem[m_ptr], m_iter});
    @(posedge clk);
    if (!m_run) begin
      if (lv) m_mem[la] = ld;
      if (st) begin
        m_run   = 1'b1;
        m_ptr   = 0;
        m_iter  = 0;
        m_steps = (ns == 0 || ns > NC) ? NC : ns;
      end
    end else begin
      if (rdy) begin
        m_ptr++;
        if (m_ptr == m_steps) begin
          m_ptr = 0;
          if (m_iter < 65535) m_iter++;
        end
      end
      if (sp) m_run = 1'b0;
    end
    #1;
    chk("ctrl_valid", 64'(ctrl_valid), 64'(m_run));
    chk("busy", 64'(busy), 64'(m_run));
    chk("load_ready", 64'(load_ready), 64'(!m_run));
    chk("iter_count", 64'(iter_count), 64'(m_iter));
`ifdef CTRL_SEQ_ITER_LIMIT_EN
    chk("done", 64'(done), 64'd0);
`endif
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    ctrl_ready = 1'b1;
    @(posedge clk);
    m_run   = 1'b0;
    m_ptr   = 0;
    m_steps = NC;
    m_iter  = 0;
    #1;
    reset = 1'b0;
    chk("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    chk("rst_iter_count", 64'(iter_count), 64'd0);
  endtask

  // Monitor: every handshake on the tile port must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && ctrl_valid && ctrl_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fire actual=fire required=no_fire data=%0h", ctrl_data);
      end else begin
        e = exp_q.pop_front();
        chk("ctrl_data", 64'(ctrl_data), 64'(e.data));
        chk("fire_iter", 64'(iter_count), 64'(e.iter));
      end
    end
  end

  initial begin
    reset = 1'b1;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    num_steps = '0; start = 1'b0; stop = 1'b0; ctrl_ready = 1'b0;
    m_run = 1'b0; m_ptr = 0; m_steps = NC; m_iter = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Load A..D, full-length run with the tile always ready.
    for (int i = 0; i < NC; i++) step(1, i, 49'hA + 49'(i), 0, 0, 0, 0);
    step(0, 0, '0, 1, 4, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1, 0);

    // Two-entry run with stalls: A, B (held), A.
    step(0, 0, '0, 1, 2, 0, 0);
    step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1, 1);

    // num_steps=0 clamps to full length; num_steps=1 repeats entry 0.
    step(0, 0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1, 0);
    step(0, 0, '0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1, 0);

    // Loads ignored while running; stop coinciding with a fire; start with a load.
    step(0, 0, '0, 1, 4, 0, 0);
    step(1, 2, rand_word(), 0, 0, 0, 1);
    step(1, 3, rand_word(), 0, 0, 1, 1);
    step(1, 1, 49'h1B, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 0, 0, 1);

    // Reset mid-run while a handshake is pending at the last entry, then restart.
    step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 1);
    do_reset();
    step(0, 0, '0, 1, 4, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), rand_word(),
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      end
    end
    step(0, 0, '0, 0, 0, 1, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
